// File: rtl/rope_motion_ctrl.sv
// rope_motion_ctrl
//   Frame-rate sequencer for the two vine ropes. Each rope cycles
//   IDLE -> EXTEND -> HOLD_LONG -> RETRACT -> HOLD_SHORT -> EXTEND ...,
//   advancing one step per effective frame tick (startOfFrame && !pause).
//   Rope 1 leaves IDLE on the first tick. Rope 2 leaves IDLE once the frame
//   counter reaches START_DELAY2.
//
// Ports
//   clk, resetN            pixel clock, async active-low reset
//   startOfFrame           one-clk pulse per video frame
//   pause                  freezes everything, including the frame counter
//   grab1 / grab2          freeze one rope (length, state, hold counter)
//   topLeftX/Y 1/2         fixed rope origins (registered)
//   length1/2              current rope length in pixels
//   active1/2              rope is not in IDLE
//   state1/2               FSM state (IDLE=0 .. HOLD_SHORT=4)

// Per-rope sequencer. The hold counter and length are frozen whenever the
// rope does not advance (no tick, or grab held).
module rope_fsm #(
    parameter logic [10:0] MIN_LEN     = 11'd8,
    parameter logic [10:0] MAX_LEN     = 11'd200,
    parameter logic [10:0] STEP        = 11'd4,
    parameter logic [7:0]  HOLD_FRAMES = 8'd30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        grab,
    input  logic        start_ok,
    output logic [2:0]  state_o,
    output logic [10:0] len_o,
    output logic        active_o
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EXTEND     = 3'd1,
        HOLD_LONG  = 3'd2,
        RETRACT    = 3'd3,
        HOLD_SHORT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [7:0]  hold_q, hold_d;
    logic        active_q, active_d;
    logic        adv;
    logic [11:0] ext_sum;
    logic [11:0] ret_floor;

    assign adv       = tick & ~grab;
    // 12-bit sum so a long rope plus STEP cannot wrap below MAX_LEN.
    assign ext_sum   = {1'b0, len_q} + {1'b0, STEP};
    // Retract clamps when one more step would reach or pass MIN_LEN,
    // so the subtraction below never underflows.
    assign ret_floor = {1'b0, MIN_LEN} + {1'b0, STEP};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (adv && start_ok) state_d = EXTEND;
            end
            EXTEND: begin
                if (adv) begin
                    if (ext_sum >= {1'b0, MAX_LEN}) begin
                        len_d   = MAX_LEN;
                        hold_d  = HOLD_FRAMES;
                        state_d = HOLD_LONG;
                    end else begin
                        len_d = ext_sum[10:0];
                    end
                end
            end
            HOLD_LONG: begin
                if (adv) begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q <= 8'd1) begin
                        hold_d  = 8'd0;
                        state_d = RETRACT;
                    end
                end
            end
            RETRACT: begin
                if (adv) begin
                    if ({1'b0, len_q} <= ret_floor) begin
                        len_d   = MIN_LEN;
                        hold_d  = HOLD_FRAMES;
                        state_d = HOLD_SHORT;
                    end else begin
                        len_d = len_q - STEP;
                    end
                end
            end
            HOLD_SHORT: begin
                if (adv) begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q <= 8'd1) begin
                        hold_d  = 8'd0;
                        state_d = EXTEND;
                    end
                end
            end
            // Corrupted encodings fall back to IDLE on the next clock,
            // independent of ticks.
            default: begin
                state_d = IDLE;
                hold_d  = 8'd0;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= MIN_LEN;
            hold_q   <= 8'd0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            hold_q   <= hold_d;
            active_q <= active_d;
        end
    end

    assign state_o  = state_q;
    assign len_o    = len_q;
    assign active_o = active_q;
endmodule

module rope_motion_ctrl #(
    parameter logic [10:0] ROPE1_X      = 11'd160,
    parameter logic [10:0] ROPE2_X      = 11'd400,
    parameter logic [10:0] ROPE_TOP_Y   = 11'd64,
    parameter logic [10:0] MIN_LEN      = 11'd8,
    parameter logic [10:0] MAX_LEN      = 11'd200,
    parameter logic [10:0] STEP         = 11'd4,
    parameter logic [7:0]  HOLD_FRAMES  = 8'd30,
    parameter logic [7:0]  START_DELAY2 = 8'd60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        pause,
    input  logic        grab1,
    input  logic        grab2,
    output logic [10:0] topLeftX1,
    output logic [10:0] topLeftY1,
    output logic [10:0] length1,
    output logic        active1,
    output logic [2:0]  state1,
    output logic [10:0] topLeftX2,
    output logic [10:0] topLeftY2,
    output logic [10:0] length2,
    output logic        active2,
    output logic [2:0]  state2
);
    localparam int NUM_ROPES = 2;

    logic                             tick;
    logic [7:0]                       frame_cnt_q, frame_cnt_d;
    logic [10:0]                      x1_q, x2_q, y_q;
    logic [NUM_ROPES-1:0]             grab_v, start_v, act_v;
    logic [NUM_ROPES-1:0][2:0]        st_v;
    logic [NUM_ROPES-1:0][10:0]       len_v;

    // pause suppresses the whole tick, so it outranks grab and the counter.
    assign tick = startOfFrame & ~pause;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (tick && frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    // Rope 2 may leave IDLE on the tick that brings the counter to
    // START_DELAY2, or on any later tick (a grab can hold it in IDLE).
    assign start_v = {({1'b0, frame_cnt_q} + 9'd1 >= {1'b0, START_DELAY2}), 1'b1};
    assign grab_v  = {grab2, grab1};

    for (genvar i = 0; i < NUM_ROPES; i++) begin : g_rope
        rope_fsm #(
            .MIN_LEN     (MIN_LEN),
            .MAX_LEN     (MAX_LEN),
            .STEP        (STEP),
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_rope (
            .clk      (clk),
            .rst_n    (resetN),
            .tick     (tick),
            .grab     (grab_v[i]),
            .start_ok (start_v[i]),
            .state_o  (st_v[i]),
            .len_o    (len_v[i]),
            .active_o (act_v[i])
        );
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q <= 8'd0;
            x1_q        <= ROPE1_X;
            x2_q        <= ROPE2_X;
            y_q         <= ROPE_TOP_Y;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            x1_q        <= x1_q;
            x2_q        <= x2_q;
            y_q         <= y_q;
        end
    end

    assign topLeftX1 = x1_q;
    assign topLeftY1 = y_q;
    assign length1   = len_v[0];
    assign active1   = act_v[0];
    assign state1    = st_v[0];
    assign topLeftX2 = x2_q;
    assign topLeftY2 = y_q;
    assign length2   = len_v[1];
    assign active2   = act_v[1];
    assign state2    = st_v[1];
endmodule

// File: tb/tb_rope_motion_ctrl.sv
module tb_rope_motion_ctrl;
    localparam int T_MIN = 8, T_MAX = 200, T_STEP = 4, T_HOLD = 30, T_DLY = 60;

    logic clk = 1'b0, resetN = 1'b1;
    logic startOfFrame = 1'b0, pause = 1'b0, grab1 = 1'b0, grab2 = 1'b0;
    logic [10:0] x1, y1, l1, x2, y2, l2;
    logic        a1, a2;
    logic [2:0]  s1, s2;
    logic [10:0] x1b, y1b, l1b, x2b, y2b, l2b;
    logic        a1b, a2b;
    logic [2:0]  s1b, s2b;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    rope_motion_ctrl u_dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
        .grab1(grab1), .grab2(grab2),
        .topLeftX1(x1), .topLeftY1(y1), .length1(l1), .active1(a1), .state1(s1),
        .topLeftX2(x2), .topLeftY2(y2), .length2(l2), .active2(a2), .state2(s2)
    );

    // Same controller with a step size that does not divide the travel.
    rope_motion_ctrl #(.STEP(11'd7)) u_dut7 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
        .grab1(grab1), .grab2(grab2),
        .topLeftX1(x1b), .topLeftY1(y1b), .length1(l1b), .active1(a1b), .state1(s1b),
        .topLeftX2(x2b), .topLeftY2(y2b), .length2(l2b), .active2(a2b), .state2(s2b)
    );

    typedef struct {
        logic [10:0] x1, y1, l1, x2, y2, l2;
        logic        a1, a2;
        logic [2:0]  s1, s2;
    } out_t;

    typedef struct {
        bit sof, p, g1, g2, rst;
        int n;
        int s1, l1, s2, l2;
    } vec_t;

    out_t exp_q[$];

    // Reference behaviour of one rope pair, stepped once per effective tick.
    int ms[2], ml[2], mh[2], mfc;

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            ms[r] = 0; ml[r] = T_MIN; mh[r] = 0;
        end
        mfc = 0;
    endtask

    task automatic model_tick(input bit g1, input bit g2);
        bit held;
        for (int r = 0; r < 2; r++) begin
            held = (r == 0) ? g1 : g2;
            if (!held) begin
                case (ms[r])
                    0: if (r == 0 || mfc + 1 >= T_DLY) ms[r] = 1;
                    1: if (ml[r] + T_STEP >= T_MAX) begin
                           ml[r] = T_MAX; mh[r] = T_HOLD; ms[r] = 2;
                       end else ml[r] = ml[r] + T_STEP;
                    2: begin mh[r] = mh[r] - 1; if (mh[r] == 0) ms[r] = 3; end
                    3: if (ml[r] - T_STEP <= T_MIN) begin
                           ml[r] = T_MIN; mh[r] = T_HOLD; ms[r] = 4;
                       end else ml[r] = ml[r] - T_STEP;
                    default: begin mh[r] = mh[r] - 1; if (mh[r] == 0) ms[r] = 1; end
                endcase
            end
        end
        if (mfc < 255) mfc = mfc + 1;
    endtask

    function automatic out_t model_out();
        out_t o;
        o.x1 = 11'd160; o.x2 = 11'd400; o.y1 = 11'd64; o.y2 = 11'd64;
        o.s1 = 3'(ms[0]); o.l1 = 11'(ml[0]); o.a1 = (ms[0] != 0);
        o.s2 = 3'(ms[1]); o.l2 = 11'(ml[1]); o.a2 = (ms[1] != 0);
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.x1 = x1; o.y1 = y1; o.l1 = l1; o.a1 = a1; o.s1 = s1;
        o.x2 = x2; o.y2 = y2; o.l2 = l2; o.a2 = a2; o.s2 = s2;
        return o;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One clock: drive inputs, push the model's expectation, compare after the edge.
    task automatic step(input bit sof, input bit p, input bit g1, input bit g2);
        out_t e, g;
        startOfFrame = sof; pause = p; grab1 = g1; grab2 = g2;
        if (sof && !p) model_tick(g1, g2);
        exp_q.push_back(model_out());
        @(posedge clk); #1;
        g = sample();
        e = exp_q.pop_front();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL sb t=%0t: got s1=%0d l1=%0d a1=%b x1=%0d s2=%0d l2=%0d a2=%b x2=%0d y=%0d/%0d expected s1=%0d l1=%0d a1=%b s2=%0d l2=%0d a2=%b",
                     $time, g.s1, g.l1, g.a1, g.x1, g.s2, g.l2, g.a2, g.x2, g.y1, g.y2,
                     e.s1, e.l1, e.a1, e.s2, e.l2, e.a2);
        end
    endtask

    task automatic tick_once(input bit p, input bit g1, input bit g2);
        step(1'b1, p, g1, g2);
        step(1'b0, 1'b0, g1, g2);
    endtask

    // Async reset asserted mid-cycle, held for 3 clocks.
    task automatic do_reset();
        startOfFrame = 0; pause = 0; grab1 = 0; grab2 = 0;
        @(posedge clk); #3;
        resetN = 1'b0;
        #1;
        chk("rst_state1", s1, 0);   chk("rst_len1", l1, T_MIN);
        chk("rst_state2", s2, 0);   chk("rst_len2", l2, T_MIN);
        chk("rst_active", {a1, a2}, 0);
        chk("rst_x1", x1, 160);     chk("rst_x2", x2, 400);
        chk("rst_y", {y1, y2}, {11'd64, 11'd64});
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[22];
        bit   bad;
        //            sof p g1 g2 rst  n   s1  l1  s2  l2
        vecs[0]  = '{1, 0, 0, 0, 0,   1, 1,   8, 0,   8};
        vecs[1]  = '{1, 0, 0, 0, 0,  48, 2, 200, 0,   8};
        vecs[2]  = '{1, 0, 0, 0, 0,  10, 2, 200, 0,   8};
        vecs[3]  = '{1, 1, 0, 0, 0,  10, 2, 200, 0,   8};
        vecs[4]  = '{1, 0, 0, 0, 0,   1, 2, 200, 1,   8};
        vecs[5]  = '{1, 0, 0, 0, 0,   1, 2, 200, 1,  12};
        vecs[6]  = '{1, 0, 0, 0, 0,  18, 3, 200, 1,  84};
        vecs[7]  = '{1, 0, 0, 0, 0,   1, 3, 196, 1,  88};
        vecs[8]  = '{1, 0, 0, 0, 0, 100, 1, 100, 3,  32};
        vecs[9]  = '{1, 0, 1, 0, 0,   5, 1, 100, 3,  12};
        vecs[10] = '{1, 0, 0, 0, 0,   1, 1, 104, 4,   8};
        vecs[11] = '{1, 0, 0, 0, 0,  55, 3, 196, 1, 108};
        vecs[12] = '{0, 0, 0, 0, 0,   5, 3, 196, 1, 108};
        vecs[13] = '{0, 0, 0, 0, 1,   0, 0,   8, 0,   8};
        vecs[14] = '{1, 0, 0, 0, 0,  59, 2, 200, 0,   8};
        vecs[15] = '{1, 0, 0, 1, 0,   3, 2, 200, 0,   8};
        vecs[16] = '{1, 0, 0, 0, 0,   1, 2, 200, 1,   8};
        vecs[17] = '{1, 0, 0, 0, 0,   1, 2, 200, 1,  12};
        vecs[18] = '{1, 1, 1, 1, 0,   3, 2, 200, 1,  12};
        vecs[19] = '{1, 0, 1, 1, 0,   2, 2, 200, 1,  12};
        vecs[20] = '{1, 0, 0, 0, 0,  15, 3, 200, 1,  72};
        vecs[21] = '{1, 0, 0, 0, 0,   1, 3, 196, 1,  76};

        model_reset();
        do_reset();

        for (int v = 0; v < 22; v++) begin
            if (vecs[v].rst) begin
                do_reset();
            end else begin
                for (int k = 0; k < vecs[v].n; k++) begin
                    if (vecs[v].sof) tick_once(vecs[v].p, vecs[v].g1, vecs[v].g2);
                    else step(1'b0, vecs[v].p, vecs[v].g1, vecs[v].g2);
                end
            end
            chk($sformatf("vec%0d_state1", v), s1, vecs[v].s1);
            chk($sformatf("vec%0d_len1", v),   l1, vecs[v].l1);
            chk($sformatf("vec%0d_state2", v), s2, vecs[v].s2);
            chk($sformatf("vec%0d_len2", v),   l2, vecs[v].l2);
        end

        // Clamp behaviour with STEP=7: 197 -> 200 on extend, 18 -> 11 -> 8 on retract.
        do_reset();
        bad = 1'b0;
        for (int t = 1; t <= 87; t++) begin
            tick_once(1'b0, 1'b0, 1'b0);
            if (l1b > 11'd200 || l1b < 11'd8) bad = 1'b1;
            if (t == 28) begin
                chk("s7_ext_pre_len", l1b, 197);  chk("s7_ext_pre_state", s1b, 1);
            end
            if (t == 29) begin
                chk("s7_ext_clamp_len", l1b, 200); chk("s7_ext_clamp_state", s1b, 2);
            end
            if (t == 59) begin
                chk("s7_retract_len", l1b, 200);   chk("s7_retract_state", s1b, 3);
            end
            if (t == 85) chk("s7_ret_len85", l1b, 18);
            if (t == 86) begin
                chk("s7_ret_len86", l1b, 11);      chk("s7_ret_state86", s1b, 3);
            end
            if (t == 87) begin
                chk("s7_ret_clamp_len", l1b, 8);   chk("s7_ret_clamp_state", s1b, 4);
            end
        end
        chk("s7_len_in_range", int'(bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rope_motion_ctrl.md
Name: rope_motion_ctrl

Overview:
- Frame-rate sequencer for the two moving vine ropes in the game playfield.
- Each rope runs its own extend/hold/retract cycle, one step per video frame.
- Outputs feed the rope draw units and, through them, the rope selection mux ahead of the VGA pixel path.
- Supports player grab freeze and a global pause.

Parameters:
ROPE1_X, 11'd160, fixed top-left X of rope 1
ROPE2_X, 11'd400, fixed top-left X of rope 2
ROPE_TOP_Y, 11'd64, fixed top-left Y of both ropes
MIN_LEN, 11'd8, retracted rope length in pixels
MAX_LEN, 11'd200, extended rope length in pixels
STEP, 11'd4, length change per frame
HOLD_FRAMES, 8'd30, frames spent in each hold state
START_DELAY2, 8'd60, frame count at which rope 2 leaves IDLE

Ports:
clk  in  1  system pixel clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame; all motion updates occur only on this pulse
pause  in  1  level; when high, no state, length or counter changes
grab1  in  1  level; player holding rope 1; freezes rope 1 length and hold counter
grab2  in  1  level; player holding rope 2; freezes rope 2 length and hold counter
topLeftX1  out  11  rope 1 X (= ROPE1_X after reset)
topLeftY1  out  11  rope 1 Y (= ROPE_TOP_Y)
length1  out  11  rope 1 current length
active1  out  1  rope 1 not in IDLE
state1  out  3  rope 1 FSM state encoding
topLeftX2, topLeftY2, length2, active2, state2  out  11/11/11/1/3  same definitions for rope 2

Behaviour:
- Clocking and reset: single clock domain. resetN low asynchronously forces:
  - both FSMs to IDLE, length1 = length2 = MIN_LEN;
  - active and hold counters to 0, frame counter to 0;
  - topLeftX/Y outputs to their parameter values.
  - Reset mid-cycle aborts any motion; no state is retained.
- Latency: all outputs are registered and change on the clk edge that samples startOfFrame=1. There are no updates on other cycles.
- Effective tick: startOfFrame && !pause. pause high with startOfFrame suppresses the tick entirely, including the frame counter.
- Frame counter: 8-bit, increments on each effective tick and saturates at 255.
- FSM per rope, state encoding: IDLE=0, EXTEND=1, HOLD_LONG=2, RETRACT=3, HOLD_SHORT=4.
  - IDLE: rope 1 moves to EXTEND on the first effective tick. Rope 2 moves to EXTEND on the tick where the frame counter reaches START_DELAY2 (pre-increment value START_DELAY2-1). Length is unchanged on the IDLE exit tick.
  - EXTEND: on each tick, length += STEP.
    - If length+STEP >= MAX_LEN: length = MAX_LEN, load hold counter = HOLD_FRAMES, go to HOLD_LONG.
    - Compute the sum at 12 bits so there is no wrap.
  - HOLD_LONG: on each tick, hold counter -= 1. On the tick where the counter goes 1->0, go to RETRACT.
  - RETRACT: on each tick, length -= STEP.
    - If length <= MIN_LEN+STEP: length = MIN_LEN, load hold counter = HOLD_FRAMES, go to HOLD_SHORT.
    - There is never an underflow.
  - HOLD_SHORT: same as HOLD_LONG, but exits to EXTEND.
- Grab: while grabN=1, that rope's FSM, length and hold counter ignore ticks. The other rope and the frame counter continue. A grab in IDLE delays the IDLE exit until release, at the next tick.
- Simultaneous events: pause has priority over grab and over ticks. grab1 and grab2 together freeze both ropes.
- Invalid state encodings (5-7) recover to IDLE on the next clk.
- active = (state != IDLE).

Test Plan:
1. Reset, then 1 tick -> state1=EXTEND, length1=8, active1=1; state2=IDLE, length2=8.
2. From reset, 49 ticks -> length1=200, state1=HOLD_LONG. A further 30 ticks -> state1=RETRACT, length1=200. Next tick -> length1=196.
3. Rope 2 start: at tick 59, state2=IDLE. At tick 60, state2=EXTEND and length2=8. At tick 61, length2=12.
4. Pause/grab: with pause=1, 10 startOfFrame pulses -> all outputs and frame counter unchanged. With grab1=1 during EXTEND at length1=100, 5 ticks -> length1 stays 100 while length2 advances 20. After release, next tick -> length1=104.
5. Clamp check with STEP=7, MIN_LEN=8, MAX_LEN=200:
   - extend reaches exactly 200 at the clamp, never 204;
   - retract reaches exactly 8, with no wrap to large values.
6. Assert resetN low mid-RETRACT for 3 clks -> immediate IDLE, length=MIN_LEN, frame counter 0. Rope 2 restarts only after 60 new ticks.
